// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and helpers for the multi-channel clock divider
package clk_div_pkg;

    localparam int DEFAULT_DIV = 2;
    localparam int MIN_DIV     = 2;
    localparam int SEL_W       = 3;

    function automatic logic sel_in_range(input logic [SEL_W-1:0] sel, input int channels);
        return int'(sel) < channels;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: shadow/active ratio, period counter, registered outputs
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             clkout,
    output logic             tick,
    output logic             pending
);

    localparam logic [CNT_W-1:0] DEF_RATIO = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] MIN_RATIO = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_prev_q, en_prev_d;
    logic             clkout_q, clkout_d;
    logic             tick_q, tick_d;
    logic             pending_q, pending_d;

    logic             restart;
    logic             wrap;
    logic [CNT_W-1:0] cnt_eff;
    logic [CNT_W-1:0] active_eff;

    // A restart (SYNC or EN rising) behaves as if the counter were already 0
    // with the shadow ratio active, so outputs for count 0 leave on this edge.
    always_comb begin
        restart    = en && (sync || !en_prev_q);
        cnt_eff    = restart ? '0 : cnt_q;
        active_eff = restart ? shadow_q : active_q;
        wrap       = en && (cnt_eff == active_eff - ONE);

        en_prev_d  = en;
        shadow_d   = shadow_q;
        if (wr) begin
            shadow_d = (wr_div < MIN_RATIO) ? MIN_RATIO : wr_div;
        end

        // Copy uses the pre-write shadow so a coincident write waits a full period.
        active_d   = wrap ? shadow_q : active_eff;
        cnt_d      = (!en || wrap) ? '0 : cnt_eff + ONE;
        clkout_d   = en && (cnt_eff < (active_eff >> 1));
        tick_d     = en && (cnt_eff == '0);

        pending_d  = pending_q;
        if (restart || wrap) begin
            pending_d = 1'b0;
        end
        if (wr) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= DEF_RATIO;
            active_q  <= DEF_RATIO;
            cnt_q     <= '0;
            en_prev_q <= 1'b0;
            clkout_q  <= 1'b0;
            tick_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            cnt_q     <= cnt_d;
            en_prev_q <= en_prev_d;
            clkout_q  <= clkout_d;
            tick_q    <= tick_d;
            pending_q <= pending_d;
        end
    end

    assign clkout  = clkout_q;
    assign tick    = tick_q;
    assign pending = pending_q;

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider with shadowed ratio writes
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CHANNELS-1:0] EN,
    input  logic                SYNC,
    input  logic                WR_EN,
    input  logic [SEL_W-1:0]    WR_SEL,
    input  logic [CNT_W-1:0]    WR_DIV,
    output logic                WR_ACK,
    output logic [CHANNELS-1:0] CLKOUT,
    output logic [CHANNELS-1:0] TICK,
    output logic [CHANNELS-1:0] PENDING
);

    logic                wr_ok;
    logic [CHANNELS-1:0] wr_hit;
    logic                wr_ack_q, wr_ack_d;

    always_comb begin
        wr_ok    = WR_EN && sel_in_range(WR_SEL, CHANNELS);
        wr_hit   = wr_ok ? (CHANNELS'(1) << WR_SEL) : '0;
        wr_ack_d = wr_ok;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ack_q <= 1'b0;
        end else begin
            wr_ack_q <= wr_ack_d;
        end
    end

    assign WR_ACK = wr_ack_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (CLK),
            .rst_n   (RST),
            .en      (EN[i]),
            .sync    (SYNC),
            .wr      (wr_hit[i]),
            .wr_div  (WR_DIV),
            .clkout  (CLKOUT[i]),
            .tick    (TICK[i]),
            .pending (PENDING[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - self-checking bench for clk_div_multi
module tb_clk_div_multi;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  EN;
    logic        SYNC;
    logic        WR_EN;
    logic [2:0]  WR_SEL;
    logic [15:0] WR_DIV;
    logic        WR_ACK;
    logic [3:0]  CLKOUT;
    logic [3:0]  TICK;
    logic [3:0]  PENDING;

    int checks = 0;
    int errors = 0;

    clk_div_multi #(.CHANNELS(4), .CNT_W(16), .DEFAULT_DIV(2)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .SYNC    (SYNC),
        .WR_EN   (WR_EN),
        .WR_SEL  (WR_SEL),
        .WR_DIV  (WR_DIV),
        .WR_ACK  (WR_ACK),
        .CLKOUT  (CLKOUT),
        .TICK    (TICK),
        .PENDING (PENDING)
    );

    always #5 CLK = ~CLK;

    // Reference: each channel tracks its position within the current period.
    int         m_shadow [4];
    int         m_ratio  [4];
    int         m_pos    [4];
    logic [3:0] m_on, m_pend, m_clk, m_tick;
    logic       m_ack;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 4; i++) begin
                m_shadow[i] = 2; m_ratio[i] = 2; m_pos[i] = 0;
            end
            m_on = '0; m_pend = '0; m_clk = '0; m_tick = '0; m_ack = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (EN[i]) begin
                    if (!m_on[i] || SYNC) begin
                        m_ratio[i] = m_shadow[i]; m_pos[i] = 0; m_pend[i] = 1'b0;
                    end
                    m_clk[i]  = (m_pos[i] < m_ratio[i] / 2);
                    m_tick[i] = (m_pos[i] == 0);
                    m_pos[i]  = m_pos[i] + 1;
                    if (m_pos[i] == m_ratio[i]) begin
                        m_pos[i] = 0; m_ratio[i] = m_shadow[i]; m_pend[i] = 1'b0;
                    end
                end else begin
                    m_clk[i] = 1'b0; m_tick[i] = 1'b0; m_pos[i] = 0;
                end
                m_on[i] = EN[i];
            end
            m_ack = WR_EN && (int'(WR_SEL) < 4);
            if (m_ack) begin
                m_shadow[int'(WR_SEL)] = (int'(WR_DIV) < 2) ? 2 : int'(WR_DIV);
                m_pend[int'(WR_SEL)]   = 1'b1;
            end
        end
    end

    task automatic test_reset();
        RST = 1'b0; EN = 4'b0001; SYNC = 0; WR_EN = 0; WR_SEL = 0; WR_DIV = 0;
        repeat (3) @(negedge CLK);
        checks++; if (CLKOUT !== 4'b0) begin errors++; $display("FAIL reset_clkout got %b want 0000", CLKOUT); end
        checks++; if (TICK !== 4'b0) begin errors++; $display("FAIL reset_tick got %b want 0000", TICK); end
        checks++; if (WR_ACK !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", WR_ACK); end
        checks++; if (PENDING !== 4'b0) begin errors++; $display("FAIL reset_pending got %b want 0000", PENDING); end
        RST = 1'b1;
    endtask

    task automatic test_basic();
        for (int k = 1; k <= 8; k++) begin
            @(negedge CLK);
            checks++; if (CLKOUT !== {3'b000, k[0]}) begin errors++; $display("FAIL basic_clkout k=%0d got %b want %b", k, CLKOUT, {3'b000, k[0]}); end
            checks++; if (TICK !== {3'b000, k[0]}) begin errors++; $display("FAIL basic_tick k=%0d got %b want %b", k, TICK, {3'b000, k[0]}); end
        end
    endtask

    task automatic test_write_mid();
        bit found = 0;
        EN = 4'b0011;
        repeat (3) @(negedge CLK);
        WR_EN = 1; WR_SEL = 1; WR_DIV = 16'd5;
        @(negedge CLK);
        WR_EN = 0;
        checks++; if (WR_ACK !== 1'b1) begin errors++; $display("FAIL wmid_ack got %b want 1", WR_ACK); end
        checks++; if (PENDING[1] !== 1'b1) begin errors++; $display("FAIL wmid_pending got %b want 1", PENDING[1]); end
        for (int c = 0; c < 12 && !found; c++) begin
            @(negedge CLK);
            if (PENDING[1] === 1'b0) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL wmid_pending_clear got 1 want 0 within 12 cycles"); end
        checks++; if (CLKOUT[1] !== 1'b0) begin errors++; $display("FAIL wmid_tail got %b want 0", CLKOUT[1]); end
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            checks++;
            if (CLKOUT[1] !== ((k % 5) == 1 || (k % 5) == 2)) begin
                errors++; $display("FAIL wmid_ratio5 k=%0d got %b want %b", k, CLKOUT[1], ((k % 5) == 1 || (k % 5) == 2));
            end
        end
    endtask

    task automatic test_clamp();
        int t2 = 0, t3 = 0;
        EN = 4'b1111; WR_EN = 1; WR_SEL = 2; WR_DIV = 16'd0;
        @(negedge CLK);
        checks++; if (WR_ACK !== 1'b1) begin errors++; $display("FAIL clamp_ack0 got %b want 1", WR_ACK); end
        WR_SEL = 3; WR_DIV = 16'd1;
        @(negedge CLK);
        checks++; if (WR_ACK !== 1'b1) begin errors++; $display("FAIL clamp_ack1 got %b want 1", WR_ACK); end
        WR_SEL = 6; WR_DIV = 16'd9;
        @(negedge CLK);
        WR_EN = 0;
        checks++; if (WR_ACK !== 1'b0) begin errors++; $display("FAIL clamp_ack_sel6 got %b want 0", WR_ACK); end
        checks++; if (PENDING !== m_pend) begin errors++; $display("FAIL clamp_pending got %b want %b", PENDING, m_pend); end
        repeat (2) @(negedge CLK);
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            t2 += int'(TICK[2]); t3 += int'(TICK[3]);
            checks++; if (CLKOUT[3:2] !== m_clk[3:2]) begin errors++; $display("FAIL clamp_clkout k=%0d got %b want %b", k, CLKOUT[3:2], m_clk[3:2]); end
        end
        checks++; if (t2 != 5) begin errors++; $display("FAIL clamp_ticks2 got %0d want 5", t2); end
        checks++; if (t3 != 5) begin errors++; $display("FAIL clamp_ticks3 got %0d want 5", t3); end
        checks++; if (PENDING !== 4'b0000) begin errors++; $display("FAIL clamp_pending_final got %b want 0000", PENDING); end
    endtask

    task automatic test_sync_align();
        int r [3] = '{3, 4, 6};
        for (int i = 0; i < 3; i++) begin
            WR_EN = 1; WR_SEL = 3'(i); WR_DIV = 16'(r[i]);
            @(negedge CLK);
        end
        WR_EN = 0; SYNC = 1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge CLK);
            SYNC = 0;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (TICK[i] !== (((k - 1) % r[i]) == 0)) begin
                    errors++; $display("FAIL align_tick ch%0d k=%0d got %b want %b", i, k, TICK[i], (((k - 1) % r[i]) == 0));
                end
            end
        end
    endtask

    task automatic test_sync_write();
        WR_EN = 1; WR_SEL = 0; WR_DIV = 16'd4;
        @(negedge CLK);
        WR_EN = 0; SYNC = 1;
        @(negedge CLK);
        SYNC = 0;
        repeat (2) @(negedge CLK);
        SYNC = 1; WR_EN = 1; WR_SEL = 0; WR_DIV = 16'd8;
        for (int k = 1; k <= 22; k++) begin
            @(negedge CLK);
            SYNC = 0; WR_EN = 0;
            checks++;
            if (TICK[0] !== (k == 1 || k == 5 || k == 13 || k == 21)) begin
                errors++; $display("FAIL syncwr_tick k=%0d got %b want %b", k, TICK[0], (k == 1 || k == 5 || k == 13 || k == 21));
            end
            if (k == 3) begin
                checks++; if (PENDING[0] !== 1'b1) begin errors++; $display("FAIL syncwr_pend_k3 got %b want 1", PENDING[0]); end
            end
            if (k == 4) begin
                checks++; if (PENDING[0] !== 1'b0) begin errors++; $display("FAIL syncwr_pend_k4 got %b want 0", PENDING[0]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        WR_EN = 1; WR_SEL = 0; WR_DIV = 16'd1000;
        @(negedge CLK);
        WR_EN = 0; SYNC = 1;
        @(negedge CLK);
        SYNC = 0;
        repeat (20) @(negedge CLK);
        WR_EN = 1; WR_SEL = 1; WR_DIV = 16'd7;
        @(negedge CLK);
        WR_EN = 0;
        checks++; if (CLKOUT[0] !== 1'b1) begin errors++; $display("FAIL rmid_pre_clkout got %b want 1", CLKOUT[0]); end
        checks++; if (WR_ACK !== 1'b1) begin errors++; $display("FAIL rmid_pre_ack got %b want 1", WR_ACK); end
        checks++; if (PENDING[1] !== 1'b1) begin errors++; $display("FAIL rmid_pre_pending got %b want 1", PENDING[1]); end
        #2 RST = 1'b0;
        #1;
        checks++; if (CLKOUT !== 4'b0) begin errors++; $display("FAIL rmid_clkout got %b want 0000", CLKOUT); end
        checks++; if (TICK !== 4'b0) begin errors++; $display("FAIL rmid_tick got %b want 0000", TICK); end
        checks++; if (WR_ACK !== 1'b0) begin errors++; $display("FAIL rmid_ack got %b want 0", WR_ACK); end
        checks++; if (PENDING !== 4'b0) begin errors++; $display("FAIL rmid_pending got %b want 0000", PENDING); end
        @(negedge CLK);
        RST = 1'b1; EN = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            checks++; if (CLKOUT !== {3'b000, k[0]}) begin errors++; $display("FAIL rmid_ratio2 k=%0d got %b want %b", k, CLKOUT, {3'b000, k[0]}); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            @(negedge CLK);
            checks++; if (CLKOUT !== m_clk) begin errors++; $display("FAIL rand_clkout c=%0d got %b want %b", c, CLKOUT, m_clk); end
            checks++; if (TICK !== m_tick) begin errors++; $display("FAIL rand_tick c=%0d got %b want %b", c, TICK, m_tick); end
            checks++; if (PENDING !== m_pend) begin errors++; $display("FAIL rand_pending c=%0d got %b want %b", c, PENDING, m_pend); end
            checks++; if (WR_ACK !== m_ack) begin errors++; $display("FAIL rand_ack c=%0d got %b want %b", c, WR_ACK, m_ack); end
            if ($urandom_range(0, 19) == 0) EN = EN ^ 4'($urandom_range(1, 15));
            SYNC   = ($urandom_range(0, 29) == 0);
            WR_EN  = ($urandom_range(0, 3) == 0);
            WR_SEL = 3'($urandom_range(0, 7));
            WR_DIV = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(10, 300)) : 16'($urandom_range(0, 9));
        end
        SYNC = 0; WR_EN = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_write_mid();
        test_clamp();
        test_sync_align();
        test_sync_write();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
